// File: rtl/jtcontra_rom_slot.sv
// Graphics ROM slot for one 007121: serves tile fetches from a one-word
// cache and turns misses into single-word SDRAM reads.
module jtcontra_rom_slot #(
    parameter int              AW     = 18,
    parameter int              SAW    = 22,
    parameter logic [SAW-1:0]  OFFSET = '0
) (
    input  logic            rst,
    input  logic            clk24,
    input  logic            rom_cs,
    input  logic [AW-1:0]   rom_addr,
    output logic [15:0]     rom_data,
    output logic            rom_ok,
    input  logic            flush,
    input  logic            downloading,
    output logic            sdram_req,
    output logic [SAW-1:0]  sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    input  logic [15:0]     data_read
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DATA = 2'd2;

    logic [1:0]    st;
    logic          cvalid;
    logic          discard;
    logic [AW-1:0] caddr;
    logic [AW-1:0] req_addr;
    logic [15:0]   cdata;
    logic          addr_hit;
    logic          miss;
    logic          fill;
    logic [SAW-1:0] ext_addr;

    assign addr_hit = cvalid & (rom_addr == caddr);
    assign rom_ok   = addr_hit & rom_cs & ~downloading;
    assign rom_data = cdata;
    assign miss     = rom_cs & ~downloading & ~addr_hit;
    assign ext_addr = SAW'(rom_addr);
    // Ack and data can land together; that still completes the read
    assign fill     = data_rdy & ((st == WAIT_DATA) |
                                  ((st == WAIT_ACK) & sdram_ack));

    always_ff @(posedge clk24) begin
        if (rst) begin
            st         <= IDLE;
            cvalid     <= 1'b0;
            discard    <= 1'b0;
            caddr      <= '0;
            req_addr   <= '0;
            cdata      <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            if (fill) begin
                cdata  <= data_read;
                caddr  <= req_addr;
                cvalid <= ~(discard | flush | downloading);
            end else if (flush | downloading) begin
                cvalid <= 1'b0;
            end
            case (st)
                IDLE: begin
                    if (miss) begin
                        req_addr   <= rom_addr;
                        sdram_addr <= OFFSET + ext_addr;
                        sdram_req  <= 1'b1;
                        discard    <= flush;
                        st         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    discard <= discard | flush | downloading;
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        st        <= data_rdy ? IDLE : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    discard <= discard | flush | downloading;
                    if (data_rdy) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
